next_pc_unit: RTL

Next-address generator that drives the program counter's `mux_inp` input from the current PC address (`addr`). It selects among sequential, conditional-branch, jump, call and return targets each cycle and keeps a small return-address stack (RAS) for call/return. It sits between the decode/ALU control outputs and the PC register, closing the fetch loop.

---
 rtl/next_pc_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/next_pc_unit.sv
// next_pc_unit: next-PC select (seq/branch/jump/call/ret) with return-address storage.
// NEXT_PC_RAS_EN defined selects a RAS_DEPTH circular stack; otherwise a single link register.
module next_pc_unit #(
    parameter int AW = 7,
    parameter int RAS_DEPTH = 4,
    parameter logic [AW-1:0] RESET_PC = AW'(1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [AW-1:0]                  pc_addr,
    input  logic                           stall,
    input  logic                           branch,
    input  logic                           zero,
    input  logic [AW-1:0]                  br_off,
    input  logic                           jump,
    input  logic                           call,
    input  logic                           ret,
    input  logic [AW-1:0]                  jump_tgt,
    output logic [AW-1:0]                  next_pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_depth,
    output logic                           ras_ovf,
    output logic                           ras_unf
);
    localparam int DW = $clog2(RAS_DEPTH+1);

    logic [AW-1:0] seq, brt, tos;
    logic          have, pop, push;

    assign seq  = pc_addr + AW'(1);
    assign brt  = seq + br_off;
    // ret beats call: a simultaneous call is dropped and never pushes
    assign pop  = !reset && !stall && ret;
    assign push = !reset && !stall && call && !ret;

    assign next_pc = reset ? RESET_PC :
                     stall ? pc_addr :
                     ret ? (have ? tos : seq) :
                     (call || jump) ? jump_tgt :
                     (branch && zero) ? brt : seq;

`ifdef NEXT_PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} ras_state_t;

    ras_state_t    state, state_next;
    logic [DW-1:0] count, count_next;
    logic [PW-1:0] top, top_next;
    logic [AW-1:0] stack [RAS_DEPTH];

    assign have      = state != EMPTY;
    assign tos       = stack[top];
    assign ras_depth = count;

    always_comb begin
        state_next = state;
        count_next = count;
        top_next   = top;
        if (pop && state != EMPTY) begin
            count_next = count - DW'(1);
            top_next   = top - PW'(1);
            state_next = (count == DW'(1)) ? EMPTY : PARTIAL;
        end else if (push) begin
            // when full, top+1 is the oldest slot, so it gets overwritten
            top_next   = top + PW'(1);
            count_next = (state == FULL) ? count : count + DW'(1);
            state_next = (state == FULL || count == DW'(RAS_DEPTH-1)) ? FULL : PARTIAL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            count   <= '0;
            top     <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            top     <= top_next;
            ras_ovf <= ras_ovf || (push && state == FULL);
            ras_unf <= ras_unf || (pop && state == EMPTY);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            stack[top_next] <= seq;
    end
`else
    logic [AW-1:0] link;
    logic          valid;

    assign have      = valid;
    assign tos       = link;
    assign ras_depth = DW'(valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else if (pop) begin
            valid   <= 1'b0;
            ras_unf <= ras_unf || !valid;
        end else if (push) begin
            valid   <= 1'b1;
            ras_ovf <= ras_ovf || valid;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            link <= seq;
    end
`endif
endmodule
